strobed_fifo: RTL and testbench
===============================

Name: strobed_fifo

Overview:
- Upstream feeder for the 8-bit clock-enabled register stage.
- Buffers ready/valid words in a small FIFO and releases one word at a time on O, with a one-cycle CE strobe.
- Release rate is set by a runtime divider, so the downstream register loads at most once every DIV+1 cycles.
- O and CE are driven straight into the register's I and CE inputs; both are registered outputs.

Parameters:
WIDTH, 8, data width of I and O
DEPTH, 4, FIFO entries; power of two, >= 2
DIV_WIDTH, 4, width of the DIV input and of the internal interval counter

Ports:
CLK  input  1  clock; all state updates on rising edge
RESET  input  1  synchronous, active-high reset
I  input  WIDTH  write data
I_valid  input  1  write request; word accepted when I_valid && I_ready at a rising edge
I_ready  output  1  = !full; combinational from registered state only (no path from I_valid)
DIV  input  DIV_WIDTH  release interval minus one; 0 = release every cycle
O  output  WIDTH  registered; last released word, held between strobes
CE  output  1  registered; high for exactly one cycle per released word

Behaviour:
- Reset (RESET=1 at an edge) has priority over all other activity, including a same-cycle push. It sets: FIFO empty, read/write pointers 0, interval counter cnt=0, O=0, CE=0. Combinationally after reset, I_ready=1.
- Reset mid-operation discards all stored words; no strobe is issued in the cycle following reset.
- Push: on an edge with I_valid && I_ready, write I at the write pointer, then increment the write pointer modulo DEPTH.
- tick = (cnt >= DIV), computed from registered cnt and the current DIV.
- Counter update on each edge: if tick, cnt <= 0; else cnt <= cnt+1.
  - Using >= means lowering DIV below the current cnt yields a tick on the next cycle; there is no long wrap.
- Pop: on an edge with tick && !empty:
  - O <= head word; CE <= 1; read pointer increments modulo DEPTH.
  - Otherwise CE <= 0 and O holds its value.
- tick while empty: the counter still wraps and no credit is stored. The next word waits for the following tick.
- No fall-through:
  - A word pushed at edge k is in the FIFO after k.
  - It can pop at the earliest at edge k+1, giving O/CE visible in the cycle after edge k+1.
  - Minimum input-to-CE latency: 2 edges.
- Full (count==DEPTH): I_ready=0. A pop in the same cycle does not make room for a same-cycle push; the freed slot is usable from the next cycle.
- Empty with a same-cycle push: the push is accepted and no pop occurs (empty is the registered state).
- Occupancy: tracked with an extra pointer wrap bit or a count register.
  - full and empty are mutually exclusive.
  - Occupancy never exceeds DEPTH and never underflows.
- DIV=0 with a FIFO that stays non-empty: CE high every cycle, with consecutive words on O, giving full throughput.
- Data ordering: strict FIFO; every accepted word appears on O exactly once with CE=1.

Optional Feature:
- Macro STROBED_FIFO_LEVEL_EN.
- Defined:
  - Adds output port LEVEL, width clog2(DEPTH)+1, equal to the current occupancy (registered state).
  - LEVEL is 0 after reset and reaches DEPTH when full.
- Undefined: no LEVEL port, no extra logic. All other behaviour is identical in both builds.

Test Plan:
- Reset then idle: RESET=1 one cycle, I_valid=0, DIV=0 -> O=0x00, CE=0, I_ready=1 for 10 cycles.
- Single word, DIV=0: push 0xDE at edge k -> CE=1 and O=0xDE in the cycle after edge k+1 only. CE=0 afterwards, O holds 0xDE.
- Throttled stream, DIV=2: push 0x01,0x02,0x03 back-to-back -> CE pulses spaced exactly 3 cycles apart, with O=0x01,0x02,0x03 in order.
- Full boundary, DEPTH=4, DIV=15:
  - Push 5 words 0x10..0x14 with I_valid held -> I_ready drops after the 4th is accepted, and 0x14 is held off.
  - At the first pop, 0x14 is accepted the next cycle.
  - Output order is 0x10..0x14.
- DIV lowered mid-count: DIV=15 with cnt=9, switch DIV to 3 while non-empty -> strobe on the next edge, then every 4 cycles.
- Reset mid-operation: 3 words queued, RESET=1 together with I_valid=1 and I=0xAA -> FIFO empty and 0xAA dropped. O=0, CE=0, and no CE until new data is pushed. With STROBED_FIFO_LEVEL_EN, LEVEL=0.

Source files
------------

// File: rtl/strobed_fifo.sv
// strobed_fifo: small ready/valid FIFO that feeds a clock-enabled register
// stage. Words are released one at a time on O with a single-cycle CE strobe,
// at most once every DIV+1 cycles.
//
// Ports:
//   CLK      clock, all state updates on the rising edge
//   RESET    synchronous active-high reset
//   I        write data
//   I_valid  write request (accepted when I_valid && I_ready)
//   I_ready  not full; depends only on registered state
//   DIV      release interval minus one (0 = every cycle)
//   O        registered, last released word
//   CE       registered, one-cycle strobe per released word
//   LEVEL    current occupancy (only when STROBED_FIFO_LEVEL_EN is defined)
//
// Build option: define STROBED_FIFO_LEVEL_EN to add the LEVEL output.
module strobed_fifo #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned DIV_WIDTH = 4
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [WIDTH-1:0]       I,
  input  logic                   I_valid,
  output logic                   I_ready,
  input  logic [DIV_WIDTH-1:0]   DIV,
  output logic [WIDTH-1:0]       O,
  output logic                   CE
`ifdef STROBED_FIFO_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0] LEVEL
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW:0]          count_q, count_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]     o_q, o_d;
  logic                 ce_q, ce_d;

  logic full, empty, tick, push, pop;

  always_comb begin
    full    = (count_q == FullCount);
    empty   = (count_q == '0);
    I_ready = !full;
    // Both push and pop look at registered occupancy only: a pop never frees a
    // slot for a same-cycle push, and a push into an empty FIFO cannot pop.
    push    = I_valid && !full;
    // >= rather than == so that lowering DIV below cnt ticks right away.
    tick    = (cnt_q >= DIV);
    pop     = tick && !empty;

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase

    // A tick while empty still restarts the interval; no credit is banked.
    cnt_d = tick ? '0 : cnt_q + DIV_WIDTH'(1);
    o_d   = pop ? mem_q[rd_ptr_q] : o_q;
    ce_d  = pop;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cnt_q    <= '0;
      o_q      <= '0;
      ce_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      cnt_q    <= cnt_d;
      o_q      <= o_d;
      ce_q     <= ce_d;
    end
  end

  // Storage needs no reset; pointers and count define which entries are live.
  always_ff @(posedge CLK) begin
    if (push && !RESET) begin
      mem_q[wr_ptr_q] <= I;
    end
  end

  assign O  = o_q;
  assign CE = ce_q;

`ifdef STROBED_FIFO_LEVEL_EN
  assign LEVEL = count_q;
`endif

endmodule

// File: tb/tb_strobed_fifo.sv
module tb_strobed_fifo;

  localparam int WIDTH     = 8;
  localparam int DEPTH     = 4;
  localparam int DIV_WIDTH = 4;

  logic                 CLK;
  logic                 RESET;
  logic [WIDTH-1:0]     I;
  logic                 I_valid;
  logic                 I_ready;
  logic [DIV_WIDTH-1:0] DIV;
  logic [WIDTH-1:0]     O;
  logic                 CE;
`ifdef STROBED_FIFO_LEVEL_EN
  logic [$clog2(DEPTH):0] LEVEL;
`endif

  strobed_fifo #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .DIV_WIDTH (DIV_WIDTH)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .I       (I),
    .I_valid (I_valid),
    .I_ready (I_ready),
    .DIV     (DIV),
    .O       (O),
    .CE      (CE)
`ifdef STROBED_FIFO_LEVEL_EN
    ,
    .LEVEL   (LEVEL)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: a queue of pending words plus an interval counter.
  logic [WIDTH-1:0] mq[$];
  int               m_cnt   = 0;
  logic [WIDTH-1:0] m_o     = '0;
  logic             m_ce    = 1'b0;
  bit               m_valid = 1'b0;
  bit               m_acc, m_tick;

  always @(posedge CLK) begin
    if (RESET) begin
      mq.delete();
      m_cnt   = 0;
      m_o     = '0;
      m_ce    = 1'b0;
      m_valid = 1'b1;
    end else begin
      m_acc  = I_valid && (mq.size() < DEPTH);
      m_tick = (m_cnt >= int'(DIV));
      if (m_tick && mq.size() > 0) begin
        m_o  = mq.pop_front();
        m_ce = 1'b1;
      end else begin
        m_ce = 1'b0;
      end
      m_cnt = m_tick ? 0 : m_cnt + 1;
      if (m_acc) mq.push_back(I);
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge CLK) begin
    if (m_valid) begin
      chk("model_o", 32'(O), 32'(m_o));
      chk("model_ce", 32'(CE), 32'(m_ce));
      chk("model_ready", 32'(I_ready), 32'(mq.size() < DEPTH));
`ifdef STROBED_FIFO_LEVEL_EN
      chk("model_level", 32'(LEVEL), 32'(mq.size()));
`endif
    end
  end

  task automatic do_reset();
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  int          n_pulse;
  int          pulse_cyc [4];
  logic [7:0]  pulse_val [4];
  logic [7:0]  nxt;
  bit          acc;

  initial begin
    RESET   = 1'b1;
    I_valid = 1'b0;
    I       = '0;
    DIV     = '0;
    @(negedge CLK);
    RESET = 1'b0;

    // Reset then idle.
    for (int c = 0; c < 10; c++) begin
      chk("idle_o", 32'(O), 32'h00);
      chk("idle_ce", 32'(CE), 32'h0);
      chk("idle_ready", 32'(I_ready), 32'h1);
      @(negedge CLK);
    end

    // Single word, DIV=0: strobe only after the second edge.
    I = 8'hDE;
    I_valid = 1'b1;
    @(negedge CLK);
    I_valid = 1'b0;
    chk("single_no_fallthrough", 32'(CE), 32'h0);
    @(negedge CLK);
    chk("single_ce", 32'(CE), 32'h1);
    chk("single_o", 32'(O), 32'hDE);
    @(negedge CLK);
    chk("single_ce_after", 32'(CE), 32'h0);
    chk("single_o_hold", 32'(O), 32'hDE);

    // Throttled stream, DIV=2: pulses exactly 3 cycles apart.
    DIV = 4'd2;
    n_pulse = 0;
    for (int c = 0; c < 20; c++) begin
      if (c < 3) begin
        I = 8'(c + 1);
        I_valid = 1'b1;
      end else begin
        I_valid = 1'b0;
      end
      @(negedge CLK);
      if (CE === 1'b1) begin
        if (n_pulse < 4) begin
          pulse_cyc[n_pulse] = c;
          pulse_val[n_pulse] = O;
        end
        n_pulse++;
      end
    end
    chk("throttle_count", 32'(n_pulse), 32'd3);
    if (n_pulse >= 3) begin
      chk("throttle_w0", 32'(pulse_val[0]), 32'h01);
      chk("throttle_w1", 32'(pulse_val[1]), 32'h02);
      chk("throttle_w2", 32'(pulse_val[2]), 32'h03);
      chk("throttle_gap0", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'd3);
      chk("throttle_gap1", 32'(pulse_cyc[2] - pulse_cyc[1]), 32'd3);
    end

    // Full boundary (DIV=15) followed by DIV lowered mid-count.
    // After reset cnt=0, so the first tick is the 16th edge.
    DIV = 4'd15;
    do_reset();
    nxt = 8'h10;
    I = nxt;
    I_valid = 1'b1;
    for (int e = 1; e <= 34; e++) begin
      acc = I_valid && I_ready;
      @(negedge CLK);
      if (acc) begin
        nxt = nxt + 8'h1;
        if (nxt <= 8'h14) I = nxt;
        else I_valid = 1'b0;
      end
      case (e)
        4:  chk("full_ready_drop", 32'(I_ready), 32'h0);
        10: chk("full_held_off", 32'(I_ready), 32'h0);
        15: chk("full_no_early_pop", 32'(CE), 32'h0);
        16: begin
          chk("full_first_pop_ce", 32'(CE), 32'h1);
          chk("full_first_pop_o", 32'(O), 32'h10);
          chk("full_room_after_pop", 32'(I_ready), 32'h1);
        end
        17: chk("full_again", 32'(I_ready), 32'h0);
        25: DIV = 4'd3;
        26: begin
          chk("div_lower_ce", 32'(CE), 32'h1);
          chk("div_lower_o", 32'(O), 32'h11);
        end
        29: chk("div_gap_quiet", 32'(CE), 32'h0);
        30: begin
          chk("div_next_ce", 32'(CE), 32'h1);
          chk("div_next_o", 32'(O), 32'h12);
        end
        34: begin
          chk("div_third_ce", 32'(CE), 32'h1);
          chk("div_third_o", 32'(O), 32'h13);
        end
        default: ;
      endcase
    end

    // Reset mid-operation with a same-cycle push.
    DIV = 4'd15;
    do_reset();
    for (int w = 0; w < 3; w++) begin
      I = 8'(8'h30 + w);
      I_valid = 1'b1;
      @(negedge CLK);
    end
    RESET = 1'b1;
    I = 8'hAA;
    I_valid = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    I_valid = 1'b0;
    chk("midreset_o", 32'(O), 32'h00);
    chk("midreset_ce", 32'(CE), 32'h0);
    chk("midreset_ready", 32'(I_ready), 32'h1);
`ifdef STROBED_FIFO_LEVEL_EN
    chk("midreset_level", 32'(LEVEL), 32'h0);
`endif
    DIV = 4'd0;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      chk("midreset_no_ce", 32'(CE), 32'h0);
    end

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      RESET   = ($urandom_range(0, 199) == 0);
      I_valid = ($urandom_range(0, 9) < 6);
      I       = 8'($urandom);
      if ($urandom_range(0, 49) == 0) begin
        if ($urandom_range(0, 3) == 0) DIV = 4'($urandom_range(0, 15));
        else DIV = 4'($urandom_range(0, 3));
      end
      @(negedge CLK);
    end
    RESET   = 1'b0;
    I_valid = 1'b0;
    DIV     = 4'd0;
    for (int c = 0; c < 20; c++) @(negedge CLK);
    chk("drain_empty_ready", 32'(I_ready), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
